// File: rtl/ioshim_pkg.sv
// ioshim_pkg
//   Shared widths and the arbiter FSM state type for the memio arbiter slice.
//   ADDR_W   : halfword address width of the CPU memory port
//   DATA_W   : data width of the CPU memory port
//   TMO_RDATA: read data returned to a requester whose access timed out
//   state_t  : arbiter state (IDLE, BUSY)
package ioshim_pkg;
   localparam int ADDR_W = 11;
   localparam int DATA_W = 16;
   localparam logic [DATA_W-1:0] TMO_RDATA = 16'hDEAD;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;
endpackage

// File: rtl/ioshim_rr_pick.sv
// ioshim_rr_pick
//   Combinational round-robin picker. The search starts at the requester
//   after the last grant and wraps around, so the last granted requester
//   has the lowest priority.
//   Parameters: NREQ  - number of requesters
//               IDX_W - width of a requester index
//   Ports:
//     i_pending    [NREQ]  per-requester pending flags
//     i_last_grant [IDX_W] index of the most recent grant
//     o_valid      [1]     at least one requester pending
//     o_grant      [IDX_W] chosen requester (0 when o_valid is low)
module ioshim_rr_pick #(
   parameter int NREQ  = 4,
   parameter int IDX_W = 2
) (
   input  logic [NREQ-1:0]  i_pending,
   input  logic [IDX_W-1:0] i_last_grant,
   output logic             o_valid,
   output logic [IDX_W-1:0] o_grant
);

   int w_idx;

   // Walk from the farthest candidate to the nearest one; the nearest
   // pending requester is assigned last and therefore wins.
   always_comb begin
      o_valid = 1'b0;
      o_grant = '0;
      w_idx   = 0;
      for (int k = NREQ; k >= 1; k--) begin
         w_idx = (int'(i_last_grant) + k) % NREQ;
         if (i_pending[w_idx]) begin
            o_valid = 1'b1;
            o_grant = IDX_W'(w_idx);
         end
      end
   end

endmodule

// File: rtl/ioshim_memio_arb.sv
// ioshim_memio_arb
//   Round-robin arbiter that lets NREQ requesters share the single CPU
//   memory port, one transaction in flight at a time.
//   Optional feature macro: IOSHIM_MEMIO_TIMEOUT_EN -- when defined, a BUSY
//   transaction that sees no memio_done within TIMEOUT cycles completes with
//   req_done + req_err and req_rdata = 16'hDEAD. When undefined, BUSY waits
//   indefinitely and req_err is tied to 0.
//   Parameters: NREQ (2..8), TIMEOUT (1..255)
//   Ports:
//     clk, resetn                 clock, async active-low reset
//     req_rd      [NREQ]          per-requester read request
//     req_wr      [2*NREQ]        per-requester byte write enables
//     req_addr    [11*NREQ]       per-requester halfword address
//     req_wdata   [16*NREQ]       per-requester write data
//     req_rdata   [16]            shared read data, valid with req_done
//     req_done    [NREQ]          one-cycle completion pulse
//     req_err     [NREQ]          one-cycle error pulse (with req_done)
//     memio_rd/wr/addr/wdata      registered CPU memory port strobes/data
//     memio_rdata, memio_done     CPU memory port response
//     o_dbg_state                 current arbiter state
//   Handshake: a requester raises rd and/or wr and holds its request and
//   data until it sees its req_done pulse. The CPU port sees steady strobes
//   for the whole BUSY period and ends it with a single-cycle memio_done.
module ioshim_memio_arb
   import ioshim_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [NREQ-1:0]        req_rd,
   input  logic [2*NREQ-1:0]      req_wr,
   input  logic [ADDR_W*NREQ-1:0] req_addr,
   input  logic [DATA_W*NREQ-1:0] req_wdata,
   output logic [DATA_W-1:0]      req_rdata,
   output logic [NREQ-1:0]        req_done,
   output logic [NREQ-1:0]        req_err,
   output logic                   memio_rd,
   output logic [1:0]             memio_wr,
   output logic [ADDR_W-1:0]      memio_addr,
   output logic [DATA_W-1:0]      memio_wdata,
   input  logic [DATA_W-1:0]      memio_rdata,
   input  logic                   memio_done,
   output state_t                 o_dbg_state
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
      $error("ioshim_memio_arb: parameter out of range");
   end

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    r_last_grant;
   logic                r_memio_rd;
   logic [1:0]          r_memio_wr;
   logic [ADDR_W-1:0]   r_memio_addr;
   logic [DATA_W-1:0]   r_memio_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic [NREQ-1:0]     r_done;

   logic [NREQ-1:0]     w_pending;
   logic                w_pick_valid;
   logic [IDX_W-1:0]    w_pick_idx;
   logic                w_grant_en;
   logic                w_tmo_hit;
   logic                w_complete;
   logic [NREQ-1:0]     w_gnt_onehot;
   logic                w_sel_rd;
   logic [1:0]          w_sel_wr;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [DATA_W-1:0]   w_sel_wdata;

   // The requester being acknowledged this cycle is masked so that a request
   // still held during its req_done cycle cannot be granted a second time.
   always_comb begin
      w_pending = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_pending[i] = (req_rd[i] | (|req_wr[2*i +: 2])) & ~r_done[i];
      end
   end

   ioshim_rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .i_pending    (w_pending),
      .i_last_grant (r_last_grant),
      .o_valid      (w_pick_valid),
      .o_grant      (w_pick_idx)
   );

   // Fields of the requester chosen by the picker.
   always_comb begin
      w_sel_rd    = 1'b0;
      w_sel_wr    = '0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (IDX_W'(i) == w_pick_idx) begin
            w_sel_rd    = req_rd[i];
            w_sel_wr    = req_wr[2*i +: 2];
            w_sel_addr  = req_addr[ADDR_W*i +: ADDR_W];
            w_sel_wdata = req_wdata[DATA_W*i +: DATA_W];
         end
      end
   end

   assign w_grant_en   = (r_state == IDLE) && w_pick_valid;
   assign w_complete   = (r_state == BUSY) && (memio_done || w_tmo_hit);
   assign w_gnt_onehot = NREQ'(1) << r_last_grant;

   // FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state; memio_done outside BUSY has no effect.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_pick_valid) w_state_nxt = BUSY;
         BUSY:    if (w_complete)   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Port strobes, grant bookkeeping and completion. Address and write data
   // are only loaded on a grant, so they keep their last value in IDLE.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_last_grant  <= LAST_RST;
         r_memio_rd    <= 1'b0;
         r_memio_wr    <= '0;
         r_memio_addr  <= '0;
         r_memio_wdata <= '0;
         r_rdata       <= '0;
         r_done        <= '0;
      end else begin
         r_done <= '0;
         if (w_grant_en) begin
            r_last_grant  <= w_pick_idx;
            r_memio_addr  <= w_sel_addr;
            r_memio_wdata <= w_sel_wdata;
            // A write takes precedence over a simultaneous read.
            if (w_sel_wr != 2'b00) begin
               r_memio_wr <= w_sel_wr;
               r_memio_rd <= 1'b0;
            end else begin
               r_memio_wr <= 2'b00;
               r_memio_rd <= w_sel_rd;
            end
         end else if (w_complete) begin
            r_memio_rd <= 1'b0;
            r_memio_wr <= 2'b00;
            r_done     <= w_gnt_onehot;
            r_rdata    <= w_tmo_hit ? TMO_RDATA : memio_rdata;
         end
      end
   end

`ifdef IOSHIM_MEMIO_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   logic [7:0]      r_tmo_cnt;
   logic [NREQ-1:0] r_err;

   // Counter reads 0 in the first BUSY cycle, so hitting TIMEOUT-1 means the
   // TIMEOUT-th BUSY cycle has passed without memio_done.
   assign w_tmo_hit = (r_state == BUSY) && !memio_done && (r_tmo_cnt == TMO_LAST);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_tmo_cnt <= '0;
         r_err     <= '0;
      end else begin
         r_err <= '0;
         if (w_grant_en) begin
            r_tmo_cnt <= '0;
         end else if (r_state == BUSY) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
         end
         if (w_tmo_hit) begin
            r_err <= w_gnt_onehot;
         end
      end
   end

   assign req_err = r_err;
`else
   assign w_tmo_hit = 1'b0;
   assign req_err   = '0;
`endif

   assign req_rdata   = r_rdata;
   assign req_done    = r_done;
   assign memio_rd    = r_memio_rd;
   assign memio_wr    = r_memio_wr;
   assign memio_addr  = r_memio_addr;
   assign memio_wdata = r_memio_wdata;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ioshim_memio_arb.sv
// tb_ioshim_memio_arb
//   Directed bench for ioshim_memio_arb with NREQ=4. Inputs are driven and
//   outputs sampled 1 ns after each rising edge.
module tb_ioshim_memio_arb;
   import ioshim_pkg::*;

   localparam int NREQ = 4;

   logic                   clk;
   logic                   resetn;
   logic [NREQ-1:0]        req_rd;
   logic [2*NREQ-1:0]      req_wr;
   logic [ADDR_W*NREQ-1:0] req_addr;
   logic [DATA_W*NREQ-1:0] req_wdata;
   logic [DATA_W-1:0]      req_rdata;
   logic [NREQ-1:0]        req_done;
   logic [NREQ-1:0]        req_err;
   logic                   memio_rd;
   logic [1:0]             memio_wr;
   logic [ADDR_W-1:0]      memio_addr;
   logic [DATA_W-1:0]      memio_wdata;
   logic [DATA_W-1:0]      memio_rdata;
   logic                   memio_done;
   state_t                 dbg_state;

   int n_pass;
   int n_chk;

   ioshim_memio_arb #(
      .NREQ    (NREQ),
      .TIMEOUT (16)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .req_rd      (req_rd),
      .req_wr      (req_wr),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_rdata   (req_rdata),
      .req_done    (req_done),
      .req_err     (req_err),
      .memio_rd    (memio_rd),
      .memio_wr    (memio_wr),
      .memio_addr  (memio_addr),
      .memio_wdata (memio_wdata),
      .memio_rdata (memio_rdata),
      .memio_done  (memio_done),
      .o_dbg_state (dbg_state)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_rd"},    32'(memio_rd),    32'h0);
      chk({tag, "_wr"},    32'(memio_wr),    32'h0);
      chk({tag, "_done"},  32'(req_done),    32'h0);
      chk({tag, "_err"},   32'(req_err),     32'h0);
   endtask

   initial begin
      n_pass      = 0;
      n_chk       = 0;
      resetn      = 1'b0;
      req_rd      = '0;
      req_wr      = '0;
      req_addr    = '0;
      req_wdata   = '0;
      memio_rdata = '0;
      memio_done  = 1'b0;

      // ---------------- reset state
      tick();
      tick();
      chk_idle_zero("rst");
      chk("rst_addr",  32'(memio_addr),  32'h0);
      chk("rst_wdata", 32'(memio_wdata), 32'h0);
      chk("rst_rdata", 32'(req_rdata),   32'h0);
      chk("rst_state", 32'(dbg_state),   32'(IDLE));
      resetn = 1'b1;
      tick();

      // ---------------- single read on requester 0
      req_rd[0]          = 1'b1;
      req_addr[10:0]     = 11'h010;
      tick();                                   // edge N+1
      chk("rd_strobe",  32'(memio_rd),   32'h1);
      chk("rd_wr",      32'(memio_wr),   32'h0);
      chk("rd_addr",    32'(memio_addr), 32'h010);
      chk("rd_state",   32'(dbg_state),  32'(BUSY));
      tick();
      chk("rd_hold",    32'(memio_rd),   32'h1);
      chk("rd_nodone",  32'(req_done),   32'h0);
      memio_done  = 1'b1;
      memio_rdata = 16'h1234;
      tick();
      chk("rd_done",    32'(req_done),   32'h1);
      chk("rd_rdata",   32'(req_rdata),  32'h1234);
      chk("rd_clr",     32'(memio_rd),   32'h0);
      memio_done = 1'b0;
      req_rd[0]  = 1'b0;
      tick();
      chk("rd_pulse1",  32'(req_done),   32'h0);
      chk("rd_addrkeep",32'(memio_addr), 32'h010);

      // ---------------- memio_done in IDLE is ignored
      memio_done  = 1'b1;
      memio_rdata = 16'hFFFF;
      tick();
      memio_done = 1'b0;
      chk_idle_zero("idle_done");
      chk("idle_rdata", 32'(req_rdata),  32'h1234);
      chk("idle_state", 32'(dbg_state),  32'(IDLE));

      // ---------------- byte write on requester 1, grant is frozen
      req_wr[3:2]      = 2'b01;
      req_addr[21:11]  = 11'h1FF;
      req_wdata[31:16] = 16'hA55A;
      tick();
      chk("bw_wr",    32'(memio_wr),    32'h1);
      chk("bw_rd",    32'(memio_rd),    32'h0);
      chk("bw_addr",  32'(memio_addr),  32'h1FF);
      chk("bw_wdata", 32'(memio_wdata), 32'hA55A);
      req_addr[21:11]  = 11'h000;
      req_wdata[31:16] = 16'h0000;
      req_wr[3:2]      = 2'b10;
      tick();
      chk("bw_frz_addr",  32'(memio_addr),  32'h1FF);
      chk("bw_frz_wdata", 32'(memio_wdata), 32'hA55A);
      chk("bw_frz_wr",    32'(memio_wr),    32'h1);
      memio_done = 1'b1;
      tick();
      chk("bw_done",  32'(req_done), 32'h2);
      chk("bw_err",   32'(req_err),  32'h0);
      memio_done  = 1'b0;
      req_wr[3:2] = 2'b00;
      tick();

      // ---------------- rd+wr conflict on requester 2, drops mid-transaction
      req_rd[2]        = 1'b1;
      req_wr[5:4]      = 2'b11;
      req_addr[32:22]  = 11'h123;
      req_wdata[47:32] = 16'hBEEF;
      tick();
      chk("cf_rd",    32'(memio_rd),    32'h0);
      chk("cf_wr",    32'(memio_wr),    32'h3);
      chk("cf_addr",  32'(memio_addr),  32'h123);
      chk("cf_wdata", 32'(memio_wdata), 32'hBEEF);
      req_rd[2]   = 1'b0;
      req_wr[5:4] = 2'b00;
      tick();
      chk("cf_keep",  32'(memio_wr),    32'h3);
      memio_done = 1'b1;
      tick();
      chk("cf_done",  32'(req_done),    32'h4);
      memio_done = 1'b0;
      tick();

      // ---------------- reset mid-BUSY (requester 3 is next after 2)
      req_rd[3]        = 1'b1;
      req_addr[43:33]  = 11'h103;
      tick();
      chk("rb_rd",    32'(memio_rd),    32'h1);
      chk("rb_addr",  32'(memio_addr),  32'h103);
      #2;
      resetn = 1'b0;
      #1;
      chk_idle_zero("rb_async");
      chk("rb_addr0",  32'(memio_addr),  32'h0);
      chk("rb_wdata0", 32'(memio_wdata), 32'h0);
      chk("rb_rdata0", 32'(req_rdata),   32'h0);
      memio_done = 1'b1;
      tick();
      memio_done = 1'b0;
      chk("rb_nodone", 32'(req_done), 32'h0);

      // ---------------- contention: all four pending after reset
      for (int i = 0; i < NREQ; i++) begin
         req_rd[i]                  = 1'b1;
         req_addr[ADDR_W*i +: ADDR_W] = 11'(32'h100 + i);
      end
      resetn = 1'b1;
      for (int k = 0; k < 5; k++) begin
         int g;
         g = k % NREQ;
         tick();
         chk($sformatf("ct%0d_rd", k),   32'(memio_rd),   32'h1);
         chk($sformatf("ct%0d_addr", k), 32'(memio_addr), 32'h100 + 32'(g));
         memio_done  = 1'b1;
         memio_rdata = 16'(32'h5000 + g);
         tick();
         memio_done = 1'b0;
         chk($sformatf("ct%0d_done", k),  32'(req_done),  32'h1 << g);
         chk($sformatf("ct%0d_rdata", k), 32'(req_rdata), 32'h5000 + 32'(g));
         chk($sformatf("ct%0d_idle", k),  32'(dbg_state), 32'(IDLE));
         chk($sformatf("ct%0d_strb", k),  32'(memio_rd),  32'h0);
      end
      req_rd = '0;
      tick();

`ifdef IOSHIM_MEMIO_TIMEOUT_EN
      // ---------------- timeout: requester 1 is next after 0
      req_rd[1]       = 1'b1;
      req_addr[21:11] = 11'h055;
      tick();
      chk("to_rd", 32'(memio_rd), 32'h1);
      for (int c = 0; c < 15; c++) tick();
      chk("to_early", 32'(req_done), 32'h0);
      tick();
      chk("to_done",  32'(req_done),  32'h2);
      chk("to_err",   32'(req_err),   32'h2);
      chk("to_rdata", 32'(req_rdata), 32'hDEAD);
      chk("to_clr",   32'(memio_rd),  32'h0);
      req_rd[1] = 1'b0;
      tick();
      chk("to_pulse1", 32'(req_err), 32'h0);
`endif

      tick();
      chk_idle_zero("end");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
